// File: rtl/mux_scan_pkg.sv
// Shared constants for the multiplexer scanner.
// FSM encodings and default geometry.
package mux_scan_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_SEL_W = $clog2(DEF_WIDTH);
    localparam int DEF_DWELL = 2;

endpackage

// File: rtl/mux_scanner_dwell_timer.sv
// Dwell counter: loads DWELL-1, counts down, flags zero.
// Idles at zero, so expired is also high outside a scan.
module dwell_timer
    import mux_scan_pkg::*;
#(
    parameter int DWELL = DEF_DWELL
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expired
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(DWELL - 1);
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/mux_scanner.sv
// Steps an external mux selector, samples Y per select value,
// and presents the assembled word with a valid/ready handshake.
module mux_scanner
    import mux_scan_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEL_W = DEF_SEL_W,
    parameter int DWELL = DEF_DWELL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [SEL_W-1:0] S,
    input  logic             Y,
    output logic [WIDTH-1:0] D,
    output logic             valid,
    input  logic             ready,
    output logic             busy
);

    logic [1:0]       state;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] next_shadow;
    logic             load;
    logic             expired;
    logic             last;

    assign last = (S == SEL_W'(WIDTH - 1));

    always_comb begin
        next_shadow    = shadow;
        next_shadow[S] = Y;
    end

    // Reload on scan start and after every non-final sample.
    assign load = ((state == IDLE) && start)
               || ((state == SETTLE) && expired && !last);

    dwell_timer #(
        .DWELL(DWELL)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            S      <= '0;
            D      <= '0;
            shadow <= '0;
        end else begin
            unique case (1'b1)
                (state == IDLE): begin
                    if (start) begin
                        state <= SETTLE;
                        S     <= '0;
                    end
                end
                (state == SETTLE): begin
                    if (expired) begin
                        shadow <= next_shadow;
                        if (last) begin
                            D     <= next_shadow;
                            S     <= '0;
                            state <= HOLD;
                        end else begin
                            S <= S + 1'b1;
                        end
                    end
                end
                (state == HOLD): begin
                    if (ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign valid = (state == HOLD);
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_mux_scanner.sv
// Bench for mux_scanner: timeline model plus directed vectors.
// Two instances cover DWELL=2 and DWELL=1.
module tb_mux_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, ready0, start1, ready1;
    logic [3:0] i0, i1;
    logic [1:0] s0, s1;
    logic       y0, y1;
    logic [3:0] d0, d1;
    logic       v0, v1, b0, b1;

    always #5 clk = ~clk;

    // Behavioural multiplexers feeding Y from the scanner's selector
    assign y0 = i0[s0];
    assign y1 = i1[s1];

    mux_scanner #(.WIDTH(4), .SEL_W(2), .DWELL(2)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .S(s0), .Y(y0),
        .D(d0), .valid(v0), .ready(ready0), .busy(b0)
    );

    mux_scanner #(.WIDTH(4), .SEL_W(2), .DWELL(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .S(s1), .Y(y1),
        .D(d1), .valid(v1), .ready(ready1), .busy(b1)
    );

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: a scan is a timeline of elapsed cycles e since start;
    // S = (e-1)/dwell, bit n taken from I during cycle (n+1)*dwell.
    int         m_mode[2] = '{0, 0};
    int         m_e[2]    = '{0, 0};
    int         m_dw[2]   = '{2, 1};
    logic [3:0] m_sh[2]   = '{4'h0, 4'h0};
    logic [3:0] m_res[2]  = '{4'h0, 4'h0};
    logic [3:0] m_iv;
    logic       m_st, m_rd;
    int         m_n;
    int         exp_s;

    always @(posedge clk) begin
        for (int j = 0; j < 2; j++) begin
            m_iv = (j == 0) ? i0 : i1;
            m_st = (j == 0) ? start0 : start1;
            m_rd = (j == 0) ? ready0 : ready1;
            if (rst) begin
                m_mode[j] = 0;
                m_e[j]    = 0;
                m_sh[j]   = 4'h0;
                m_res[j]  = 4'h0;
            end else if (m_mode[j] == 0) begin
                if (m_st) begin
                    m_mode[j] = 1;
                    m_e[j]    = 1;
                end
            end else if (m_mode[j] == 1) begin
                if (m_e[j] % m_dw[j] == 0) begin
                    m_n           = m_e[j] / m_dw[j] - 1;
                    m_sh[j][m_n]  = m_iv[m_n];
                end
                if (m_e[j] == 4 * m_dw[j]) begin
                    m_res[j]  = m_sh[j];
                    m_mode[j] = 2;
                end else begin
                    m_e[j]++;
                end
            end else if (m_rd) begin
                m_mode[j] = 0;
            end
        end
        #1;
        for (int j = 0; j < 2; j++) begin
            exp_s = (m_mode[j] == 1) ? (m_e[j] - 1) / m_dw[j] : 0;
            chk(j ? "S_dw1" : "S_dw2", j ? s1 : s0, exp_s);
            chk(j ? "D_dw1" : "D_dw2", j ? d1 : d0, m_res[j]);
            chk(j ? "valid_dw1" : "valid_dw2", j ? v1 : v0,
                (m_mode[j] == 2) ? 1 : 0);
            chk(j ? "busy_dw1" : "busy_dw2", j ? b1 : b0,
                (m_mode[j] != 0) ? 1 : 0);
        end
    end

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic scan0(input logic [3:0] pat);
        i0     = pat;
        cyc    = 0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
    endtask

    task automatic wait_v0();
        while (!v0 && cyc < 60) tick();
    endtask

    int ok;
    int nval;

    initial begin
        rst = 1'b1;
        start0 = 1'b0; ready0 = 1'b0; i0 = 4'h0;
        start1 = 1'b0; ready1 = 1'b1; i1 = 4'h0;
        repeat (2) @(negedge clk);
        chk("rst_S", s0, 0);
        chk("rst_D", d0, 0);
        chk("rst_valid", v0, 0);
        rst = 1'b0;
        tick();

        // Basic scan, valid in cycle 9
        ready0 = 1'b1;
        scan0(4'b1010);
        chk("t1_S_c1", s0, 0);
        tick(); tick();
        chk("t1_S_c3", s0, 1);
        wait_v0();
        chk("t1_lat", cyc, 9);
        chk("t1_D", d0, 4'b1010);
        tick();
        chk("t1_vlow", v0, 0);
        tick();

        // Consumer stalls for 20 cycles
        ready0 = 1'b0;
        scan0(4'b0110);
        wait_v0();
        ok = 1;
        repeat (20) begin
            tick();
            if (!(v0 && d0 == 4'b0110)) ok = 0;
        end
        chk("t2_hold", ok, 1);
        ready0 = 1'b1;
        tick();
        chk("t2_idle_v", v0, 0);
        chk("t2_idle_b", b0, 0);
        tick();

        // Restarts in cycles 3 and 9 are ignored or dropped
        scan0(4'b1111);
        while (cyc < 3) tick();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        while (cyc < 9) tick();
        chk("t3_lat", v0, 1);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        nval = 0;
        repeat (20) begin
            if (v0 || b0) nval++;
            tick();
        end
        chk("t3_once", nval, 0);
        chk("t3_D", d0, 4'b1111);

        // Reset mid-scan, then a clean scan
        scan0(4'b1010);
        while (cyc < 5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_S", s0, 0);
        chk("t4_D", d0, 0);
        chk("t4_valid", v0, 0);
        tick();
        scan0(4'b1100);
        wait_v0();
        chk("t4_lat", cyc, 9);
        chk("t4_D2", d0, 4'b1100);
        tick();
        tick();

        // Input changes after bit 1 is taken
        scan0(4'b1010);
        while (cyc < 5) tick();
        i0 = 4'b0101;
        wait_v0();
        chk("t6_D", d0, 4'b0110);
        tick();
        tick();

        // DWELL=1: one sample per cycle
        i1 = 4'b0001;
        cyc = 0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("t5_S_c1", s1, 0);
        tick();
        chk("t5_S_c2", s1, 1);
        while (!v1 && cyc < 60) tick();
        chk("t5_lat", cyc, 5);
        chk("t5_D", d1, 4'b0001);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
